biriscv_csr_commit: RTL and testbench
=====================================

// Module: biriscv_csr_commit
// PURPOSE
//  Writeback-side partner of the CSR execute unit. Carries E1 CSR results through E2 and WB.
//  Merges late memory faults and pending interrupts into each instruction's exception.
//  Drives csr_writeback_* back into the CSR unit, exactly one commit per instruction.
//  Flushes younger work when an exception retires.
// PARAMETERS
//  SUPPORT_MEM_FAULT  1  1: merge mem_exception_e2_i/mem_addr_e2_i; 0: tie off and ignore them
// PORTS
//  clk                     in   1   clock
//  rst                     in   1   reset, asynchronous, active-high
//  opcode_valid_e1_i       in   1   instruction valid in E1
//  opcode_opcode_e1_i      in   32  E1 opcode (CSR addr = [31:20])
//  opcode_pc_e1_i          in   32  E1 PC
//  csr_result_e1_value_i   in   32  CSR read value, or opcode on fault (becomes tval)
//  csr_result_e1_write_i   in   1   E1 CSR write request
//  csr_result_e1_wdata_i   in   32  E1 CSR write data
//  csr_result_e1_exception_i in 6   E1 exception code (0 = none)
//  mem_exception_e2_i      in   6   E2 load/store fault code
//  mem_addr_e2_i           in   32  E2 faulting address
//  take_interrupt_i        in   1   interrupt pending (level)
//  stall_i                 in   1   pipeline hold
//  squash_e2_i             in   1   kill E2 contents (branch mispredict)
//  csr_writeback_write_o   out  1   CSR write strobe
//  csr_writeback_waddr_o   out  12  CSR write address
//  csr_writeback_wdata_o   out  32  CSR write data
//  csr_writeback_exception_o out 6  retiring exception code
//  csr_writeback_exception_pc_o out 32   PC of retiring instruction
//  csr_writeback_exception_addr_o out 32 tval: mem addr or E1 value
//  flush_o                 out  1   pulse: exception retired, kill younger
// BEHAVIOUR
//  - Reset: all outputs 0; E2/WB valid = 0. Async assert, sync release.
//  - Stages E2, WB. E1->WB latency 2 cycles when unstalled.
//  - stall_i=1: E1->E2 capture blocked and E2 held. WB loads a bubble.
//    All outputs return to 0 next cycle, so no commit repeats.
//  - E2 exception merge, priority high->low:
//    1. E1 code != 0.
//    2. mem_exception_e2_i != 0 (SUPPORT_MEM_FAULT), addr = mem_addr_e2_i.
//    3. take_interrupt_i with E2 valid: code = `EXCEPTION_INTERRUPT, PC = E2 pc.
//    4. Otherwise 0.
//  - CSR write commits (write_o=1, waddr=opcode[31:20]) only when WB valid and write_req.
//    Exception must be 0 or `EXCEPTION_FENCE; any other code suppresses it.
//  - Exception retires (WB valid, code != 0): exception_o/pc_o/addr_o valid for 1 cycle.
//    flush_o=1 same cycle.
//  - Same edge: E2 becomes a bubble and E1 is not captured. This takes priority over stall_i.
//  - squash_e2_i: E2 becomes a bubble next edge; WB unaffected. squash and stall together: squash wins.
//  - Interrupt is attached to at most one instruction: suppressed in E2 while WB holds any exception.
//  - Invalid stages produce all-zero outputs; addresses/data never leak on write_o=0.
// CONFIGURATION
//  BIRISCV_CSR_COMMIT_INSTRET_EN defined:
//    - adds output instret_o [63:0], reset 0.
//    - +1 per WB-valid instruction with code 0, `EXCEPTION_FENCE or ERET; wraps 2^64-1 -> 0.
//  Undefined: no counter, no port.
// STRUCTURE
//  Shared defs (biriscv_defs.v): `EXCEPTION_W, `EXCEPTION_INTERRUPT, `EXCEPTION_FENCE, ERET/ECALL codes.
//  One sub-module biriscv_csr_commit_stage (valid + payload register, hold/kill/bubble),
//  instanced for E2 and WB. Merge/commit logic stays top-level.
// TESTING
//  1. csrrw 0x340 wdata 0xDEAD_BEEF at E1, no stall -> 2 cycles later: write_o=1, waddr=0x340,
//     wdata=0xDEAD_BEEF, exception_o=0 for exactly 1 cycle.
//  2. E1 exc=ILLEGAL, value=0x3400_1073, pc=0x8000_0010 -> WB: exception_o=ILLEGAL, pc=0x8000_0010,
//     addr=0x3400_1073, flush_o=1; write_o=0; following E1 instr never commits.
//  3. Load at E2 with mem_exception=LOAD_FAULT, addr 0x1000_0003, plus take_interrupt_i=1
//     -> LOAD_FAULT retires with addr 0x1000_0003; interrupt taken on next instr, not same.
//  4. stall_i held 3 cycles with CSR write in E2 -> write_o pulses once, 1 cycle after stall drops.
//  5. squash_e2_i with CSR write in E2 -> no commit; simultaneous WB exception + stall -> flush_o=1, E2 killed.
//  6. rst asserted mid-commit (write_o=1) -> all outputs 0 immediately; no commit after release until new E1.

Source files
------------

// File: rtl/biriscv_csr_commit_pkg.sv
// Shared exception codes and stage payload types for the CSR commit path.
// Combinational definitions only; no latency or backpressure of its own.
package biriscv_csr_commit_pkg;

    localparam int EXCEPTION_W = 6;
    typedef logic [EXCEPTION_W-1:0] exc_t;

    localparam exc_t EXCEPTION_NONE                = 6'h00;
    localparam exc_t EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
    localparam exc_t EXCEPTION_BREAKPOINT          = 6'h13;
    localparam exc_t EXCEPTION_FAULT_LOAD          = 6'h15;
    localparam exc_t EXCEPTION_FAULT_STORE         = 6'h17;
    localparam exc_t EXCEPTION_ECALL_M             = 6'h1b;
    localparam exc_t EXCEPTION_INTERRUPT           = 6'h20;
    localparam exc_t EXCEPTION_ERET_U              = 6'h30;
    localparam exc_t EXCEPTION_ERET_M              = 6'h33;
    localparam exc_t EXCEPTION_FENCE               = 6'h34;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] waddr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] value;
        exc_t        exc;
    } e2_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] waddr;
        logic        write;
        logic [31:0] wdata;
        exc_t        exc;
        logic [31:0] addr;
    } wb_t;

    // FENCE travels as an exception code but must not block its own CSR write.
    function automatic logic exc_allows_write(exc_t code);
        return (code == EXCEPTION_NONE) || (code == EXCEPTION_FENCE);
    endfunction

    // ERET_U..ERET_M share the 0b1100xx prefix.
    function automatic logic exc_counts_retire(exc_t code);
        return exc_allows_write(code) || (code[5:2] == 4'b1100);
    endfunction

endpackage

// File: rtl/biriscv_csr_commit_if.sv
// E1/E2 inputs and CSR writeback outputs between the pipeline and the commit block.
// instret_o exists only when BIRISCV_CSR_COMMIT_INSTRET_EN is defined.
interface biriscv_csr_commit_if;
    import biriscv_csr_commit_pkg::*;

    logic        opcode_valid_e1_i;
    logic [31:0] opcode_opcode_e1_i;
    logic [31:0] opcode_pc_e1_i;
    logic [31:0] csr_result_e1_value_i;
    logic        csr_result_e1_write_i;
    logic [31:0] csr_result_e1_wdata_i;
    exc_t        csr_result_e1_exception_i;
    exc_t        mem_exception_e2_i;
    logic [31:0] mem_addr_e2_i;
    logic        take_interrupt_i;
    logic        stall_i;
    logic        squash_e2_i;

    logic        csr_writeback_write_o;
    logic [11:0] csr_writeback_waddr_o;
    logic [31:0] csr_writeback_wdata_o;
    exc_t        csr_writeback_exception_o;
    logic [31:0] csr_writeback_exception_pc_o;
    logic [31:0] csr_writeback_exception_addr_o;
    logic        flush_o;
`ifdef BIRISCV_CSR_COMMIT_INSTRET_EN
    logic [63:0] instret_o;
`endif

    modport master (
`ifdef BIRISCV_CSR_COMMIT_INSTRET_EN
        input  instret_o,
`endif
        output opcode_valid_e1_i, opcode_opcode_e1_i, opcode_pc_e1_i,
        output csr_result_e1_value_i, csr_result_e1_write_i, csr_result_e1_wdata_i,
        output csr_result_e1_exception_i, mem_exception_e2_i, mem_addr_e2_i,
        output take_interrupt_i, stall_i, squash_e2_i,
        input  csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
        input  csr_writeback_exception_o, csr_writeback_exception_pc_o,
        input  csr_writeback_exception_addr_o, flush_o
    );

    modport slave (
`ifdef BIRISCV_CSR_COMMIT_INSTRET_EN
        output instret_o,
`endif
        input  opcode_valid_e1_i, opcode_opcode_e1_i, opcode_pc_e1_i,
        input  csr_result_e1_value_i, csr_result_e1_write_i, csr_result_e1_wdata_i,
        input  csr_result_e1_exception_i, mem_exception_e2_i, mem_addr_e2_i,
        input  take_interrupt_i, stall_i, squash_e2_i,
        output csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
        output csr_writeback_exception_o, csr_writeback_exception_pc_o,
        output csr_writeback_exception_addr_o, flush_o
    );

endinterface

// File: rtl/biriscv_csr_commit_stage.sv
// One pipeline slot (valid + payload), 1-cycle latency.
// kill_i beats hold_i; held slots keep contents; empty slots carry an all-zero payload.
module biriscv_csr_commit_stage #(
    parameter type payload_t = logic [31:0]
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     kill_i,
    input  logic     hold_i,
    input  logic     valid_i,
    input  payload_t payload_i,
    output logic     valid_o,
    output payload_t payload_o
);

    logic     valid_q, valid_d;
    payload_t payload_q, payload_d;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (kill_i) begin
            valid_d   = 1'b0;
            payload_d = '0;
        end else if (!hold_i) begin
            valid_d   = valid_i;
            payload_d = valid_i ? payload_i : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/biriscv_csr_commit.sv
// CSR commit: E1 -> E2 -> WB (2 cycles), merges mem faults/interrupts, one commit per instruction.
// stall_i holds E2 and bubbles WB; a retiring exception flushes E2/E1. Optional: BIRISCV_CSR_COMMIT_INSTRET_EN.
module biriscv_csr_commit
    import biriscv_csr_commit_pkg::*;
#(
    parameter bit SUPPORT_MEM_FAULT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    biriscv_csr_commit_if.slave       bus
);

    // Reset asserts immediately but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_core;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst_core = rst_sync_q[1];

    e2_t         e1_pay, e2_q;
    wb_t         wb_d, wb_q;
    logic        e2_vld, wb_vld;
    logic        flush, commit_write;
    exc_t        mem_exc;
    logic [31:0] mem_addr;

    assign e1_pay.pc    = bus.opcode_pc_e1_i;
    assign e1_pay.waddr = bus.opcode_opcode_e1_i[31:20];
    assign e1_pay.write = bus.csr_result_e1_write_i;
    assign e1_pay.wdata = bus.csr_result_e1_wdata_i;
    assign e1_pay.value = bus.csr_result_e1_value_i;
    assign e1_pay.exc   = bus.csr_result_e1_exception_i;

    assign mem_exc  = SUPPORT_MEM_FAULT ? bus.mem_exception_e2_i : EXCEPTION_NONE;
    assign mem_addr = SUPPORT_MEM_FAULT ? bus.mem_addr_e2_i      : 32'h0;

    assign flush = wb_vld && (wb_q.exc != EXCEPTION_NONE);

    biriscv_csr_commit_stage #(.payload_t(e2_t)) u_e2 (
        .clk       (clk),
        .rst       (rst_core),
        .kill_i    (flush || bus.squash_e2_i),
        .hold_i    (bus.stall_i),
        .valid_i   (bus.opcode_valid_e1_i),
        .payload_i (e1_pay),
        .valid_o   (e2_vld),
        .payload_o (e2_q)
    );

    // An interrupt is withheld while WB retires an exception so it lands on exactly one instruction.
    always_comb begin
        wb_d       = '0;
        wb_d.pc    = e2_q.pc;
        wb_d.waddr = e2_q.waddr;
        wb_d.write = e2_q.write;
        wb_d.wdata = e2_q.wdata;
        if (e2_q.exc != EXCEPTION_NONE) begin
            wb_d.exc  = e2_q.exc;
            wb_d.addr = e2_q.value;
        end else if (mem_exc != EXCEPTION_NONE) begin
            wb_d.exc  = mem_exc;
            wb_d.addr = mem_addr;
        end else if (bus.take_interrupt_i && e2_vld && !flush) begin
            wb_d.exc  = EXCEPTION_INTERRUPT;
        end
    end

    // Anything leaving E2 on a stall, squash or flush edge is dropped rather than retired.
    biriscv_csr_commit_stage #(.payload_t(wb_t)) u_wb (
        .clk       (clk),
        .rst       (rst_core),
        .kill_i    (bus.stall_i || bus.squash_e2_i || flush),
        .hold_i    (1'b0),
        .valid_i   (e2_vld),
        .payload_i (wb_d),
        .valid_o   (wb_vld),
        .payload_o (wb_q)
    );

    assign commit_write = wb_vld && wb_q.write && exc_allows_write(wb_q.exc);

    assign bus.csr_writeback_write_o          = commit_write;
    assign bus.csr_writeback_waddr_o          = commit_write ? wb_q.waddr : 12'h0;
    assign bus.csr_writeback_wdata_o          = commit_write ? wb_q.wdata : 32'h0;
    assign bus.csr_writeback_exception_o      = flush ? wb_q.exc  : EXCEPTION_NONE;
    assign bus.csr_writeback_exception_pc_o   = flush ? wb_q.pc   : 32'h0;
    assign bus.csr_writeback_exception_addr_o = flush ? wb_q.addr : 32'h0;
    assign bus.flush_o                        = flush;

`ifdef BIRISCV_CSR_COMMIT_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (wb_vld && exc_counts_retire(wb_q.exc)) instret_d = instret_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst_core) begin
        if (rst_core) instret_q <= 64'h0;
        else          instret_q <= instret_d;
    end

    assign bus.instret_o = instret_q;
`endif

    wire unused_ok = &{1'b0, bus.opcode_opcode_e1_i[19:0], bus.mem_exception_e2_i,
                       bus.mem_addr_e2_i, 1'b0};

endmodule

// File: tb/tb_biriscv_csr_commit.sv
// Directed bench for biriscv_csr_commit: commit timing, exception merge, stall/squash/flush, reset.
module tb_biriscv_csr_commit;
    import biriscv_csr_commit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    biriscv_csr_commit_if bus();

    biriscv_csr_commit #(.SUPPORT_MEM_FAULT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] csr_op(input logic [11:0] csr);
        return {csr, 20'h29073};
    endfunction

    task automatic e1(input logic [31:0] pc, input logic [31:0] op, input logic [31:0] val,
                      input logic wr, input logic [31:0] wd, input logic [5:0] exc);
        bus.opcode_valid_e1_i         = 1'b1;
        bus.opcode_pc_e1_i            = pc;
        bus.opcode_opcode_e1_i        = op;
        bus.csr_result_e1_value_i     = val;
        bus.csr_result_e1_write_i     = wr;
        bus.csr_result_e1_wdata_i     = wd;
        bus.csr_result_e1_exception_i = exc;
    endtask

    task automatic e1_idle();
        bus.opcode_valid_e1_i         = 1'b0;
        bus.opcode_pc_e1_i            = 32'h0;
        bus.opcode_opcode_e1_i        = 32'h0;
        bus.csr_result_e1_value_i     = 32'h0;
        bus.csr_result_e1_write_i     = 1'b0;
        bus.csr_result_e1_wdata_i     = 32'h0;
        bus.csr_result_e1_exception_i = 6'h0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        e1_idle();
        bus.mem_exception_e2_i = 6'h0;
        bus.mem_addr_e2_i      = 32'h0;
        bus.take_interrupt_i   = 1'b0;
        bus.stall_i            = 1'b0;
        bus.squash_e2_i        = 1'b0;
        #2;
        check("rst_write",  64'(bus.csr_writeback_write_o), 64'h0);
        check("rst_flush",  64'(bus.flush_o), 64'h0);
        check("rst_exc",    64'(bus.csr_writeback_exception_o), 64'h0);
        check("rst_pc",     64'(bus.csr_writeback_exception_pc_o), 64'h0);
        step();
        rst = 1'b0;
        step(); step(); step();

        // 1: plain CSR write commits two edges after E1
        e1(32'h8000_0000, csr_op(12'h340), 32'h0, 1'b1, 32'hDEAD_BEEF, 6'h0);
        step();
        e1_idle();
        check("t1_e2_nowrite", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        check("t1_write", 64'(bus.csr_writeback_write_o), 64'h1);
        check("t1_waddr", 64'(bus.csr_writeback_waddr_o), 64'h340);
        check("t1_wdata", 64'(bus.csr_writeback_wdata_o), 64'hDEAD_BEEF);
        check("t1_exc",   64'(bus.csr_writeback_exception_o), 64'h0);
        check("t1_flush", 64'(bus.flush_o), 64'h0);
        step();
        check("t1_once",  64'(bus.csr_writeback_write_o), 64'h0);
        check("t1_waddr0", 64'(bus.csr_writeback_waddr_o), 64'h0);
        check("t1_wdata0", 64'(bus.csr_writeback_wdata_o), 64'h0);

        // 2: illegal instruction retires, suppresses its write, flushes younger work
        e1(32'h8000_0010, 32'h3400_1073, 32'h3400_1073, 1'b1, 32'h0000_00AA, 6'h12);
        step();
        e1(32'h8000_0014, csr_op(12'h341), 32'h0, 1'b1, 32'h1111_1111, 6'h0);
        step();
        e1(32'h8000_0018, csr_op(12'h342), 32'h0, 1'b1, 32'h2222_2222, 6'h0);
        check("t2_exc",   64'(bus.csr_writeback_exception_o), 64'h12);
        check("t2_pc",    64'(bus.csr_writeback_exception_pc_o), 64'h8000_0010);
        check("t2_addr",  64'(bus.csr_writeback_exception_addr_o), 64'h3400_1073);
        check("t2_flush", 64'(bus.flush_o), 64'h1);
        check("t2_nowrite", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        e1_idle();
        check("t2_killed_e2", 64'(bus.csr_writeback_write_o), 64'h0);
        check("t2_flush_once", 64'(bus.flush_o), 64'h0);
        step();
        check("t2_e1_dropped", 64'(bus.csr_writeback_write_o), 64'h0);

        // 3: load fault beats interrupt; interrupt lands on a later instruction
        e1(32'h8000_0100, 32'h0000_2003, 32'h0, 1'b0, 32'h0, 6'h0);
        step();
        e1(32'h8000_0104, csr_op(12'h343), 32'h0, 1'b1, 32'h3333_3333, 6'h0);
        bus.mem_exception_e2_i = 6'h15;
        bus.mem_addr_e2_i      = 32'h1000_0003;
        bus.take_interrupt_i   = 1'b1;
        step();
        e1_idle();
        bus.mem_exception_e2_i = 6'h0;
        bus.mem_addr_e2_i      = 32'h0;
        check("t3_exc",   64'(bus.csr_writeback_exception_o), 64'h15);
        check("t3_addr",  64'(bus.csr_writeback_exception_addr_o), 64'h1000_0003);
        check("t3_pc",    64'(bus.csr_writeback_exception_pc_o), 64'h8000_0100);
        check("t3_flush", 64'(bus.flush_o), 64'h1);
        step();
        check("t3_no_dup_int", 64'(bus.csr_writeback_exception_o), 64'h0);
        e1(32'h8000_0200, 32'h0000_0013, 32'h0, 1'b0, 32'h0, 6'h0);
        step();
        e1_idle();
        check("t3_bubble", 64'(bus.flush_o), 64'h0);
        step();
        bus.take_interrupt_i = 1'b0;
        check("t3_int_exc", 64'(bus.csr_writeback_exception_o), 64'h20);
        check("t3_int_pc",  64'(bus.csr_writeback_exception_pc_o), 64'h8000_0200);
        check("t3_int_addr", 64'(bus.csr_writeback_exception_addr_o), 64'h0);
        step();
        check("t3_int_once", 64'(bus.csr_writeback_exception_o), 64'h0);

        // 4: three stall cycles with a CSR write parked in E2
        e1(32'h8000_0300, csr_op(12'h305), 32'h0, 1'b1, 32'h8000_0004, 6'h0);
        step();
        e1_idle();
        bus.stall_i = 1'b1;
        check("t4_pre", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        check("t4_stall1", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        check("t4_stall2", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        check("t4_stall3", 64'(bus.csr_writeback_write_o), 64'h0);
        bus.stall_i = 1'b0;
        step();
        check("t4_write", 64'(bus.csr_writeback_write_o), 64'h1);
        check("t4_waddr", 64'(bus.csr_writeback_waddr_o), 64'h305);
        check("t4_wdata", 64'(bus.csr_writeback_wdata_o), 64'h8000_0004);
        step();
        check("t4_once", 64'(bus.csr_writeback_write_o), 64'h0);

        // 5a: squash kills the E2 write
        e1(32'h8000_0400, csr_op(12'h306), 32'h0, 1'b1, 32'h5555_5555, 6'h0);
        step();
        e1_idle();
        bus.squash_e2_i = 1'b1;
        step();
        bus.squash_e2_i = 1'b0;
        check("t5_squash_a", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        check("t5_squash_b", 64'(bus.csr_writeback_write_o), 64'h0);

        // 5b: retiring exception during stall still flushes E2
        e1(32'h8000_0500, 32'h0000_0073, 32'h0, 1'b0, 32'h0, 6'h1b);
        step();
        e1(32'h8000_0504, csr_op(12'h307), 32'h0, 1'b1, 32'h6666_6666, 6'h0);
        step();
        bus.stall_i = 1'b1;
        e1(32'h8000_0508, csr_op(12'h308), 32'h0, 1'b1, 32'h7777_7777, 6'h0);
        check("t5_flush",  64'(bus.flush_o), 64'h1);
        check("t5_exc",    64'(bus.csr_writeback_exception_o), 64'h1b);
        check("t5_pc",     64'(bus.csr_writeback_exception_pc_o), 64'h8000_0500);
        step();
        bus.stall_i = 1'b0;
        e1_idle();
        check("t5_flush_once", 64'(bus.flush_o), 64'h0);
        step();
        check("t5_e2_killed", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        check("t5_e1_dropped", 64'(bus.csr_writeback_write_o), 64'h0);

        // E1 exception outranks a simultaneous memory fault
        e1(32'h8000_0700, 32'h0010_0073, 32'hABCD_0000, 1'b0, 32'h0, 6'h13);
        step();
        e1_idle();
        bus.mem_exception_e2_i = 6'h17;
        bus.mem_addr_e2_i      = 32'h2000_0000;
        step();
        bus.mem_exception_e2_i = 6'h0;
        bus.mem_addr_e2_i      = 32'h0;
        check("prio_exc",  64'(bus.csr_writeback_exception_o), 64'h13);
        check("prio_addr", 64'(bus.csr_writeback_exception_addr_o), 64'hABCD_0000);
        step();

        // FENCE code still lets its CSR write through
        e1(32'h8000_0800, csr_op(12'h7c0), 32'h0, 1'b1, 32'h0000_1234, 6'h34);
        step();
        e1_idle();
        step();
        check("fence_write", 64'(bus.csr_writeback_write_o), 64'h1);
        check("fence_waddr", 64'(bus.csr_writeback_waddr_o), 64'h7c0);
        check("fence_exc",   64'(bus.csr_writeback_exception_o), 64'h34);
        check("fence_flush", 64'(bus.flush_o), 64'h1);
        step();

        // 6: reset in the middle of a commit
        e1(32'h8000_0600, csr_op(12'h309), 32'h0, 1'b1, 32'h7777_0000, 6'h0);
        step();
        e1_idle();
        step();
        check("t6_pre_write", 64'(bus.csr_writeback_write_o), 64'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_write", 64'(bus.csr_writeback_write_o), 64'h0);
        check("t6_rst_waddr", 64'(bus.csr_writeback_waddr_o), 64'h0);
        check("t6_rst_wdata", 64'(bus.csr_writeback_wdata_o), 64'h0);
        step();
        rst = 1'b0;
        step();
        check("t6_rel1", 64'(bus.csr_writeback_write_o), 64'h0);
        step();
        step();
        check("t6_rel3", 64'(bus.csr_writeback_write_o), 64'h0);
        e1(32'h8000_0610, csr_op(12'h30a), 32'h0, 1'b1, 32'h8888_8888, 6'h0);
        step();
        e1_idle();
        step();
        check("t6_new_write", 64'(bus.csr_writeback_write_o), 64'h1);
        check("t6_new_waddr", 64'(bus.csr_writeback_waddr_o), 64'h30a);
        step();
        check("t6_new_once", 64'(bus.csr_writeback_write_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
